// File: rtl/thread_writeback.sv
// Per-thread result collector: latches rd/source of a register-writing instruction,
// waits for the selected unit's Q1.15 result and issues a single write during UPDATE.
module thread_writeback #(
   parameter int unsigned DATA_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_reg_write_enable,
   input  logic [3:0]           decoded_rd_address,
   input  logic [2:0]           decoded_reg_input_mux,
   input  logic [7:0]           decoded_immediate,
   input  logic [DATA_BITS-1:0] alu_out,
   input  logic [DATA_BITS-1:0] lsu_out,
   input  logic                 lsu_valid,
   input  logic [DATA_BITS-1:0] fma_out,
   input  logic                 fma_valid,
   input  logic [DATA_BITS-1:0] act_out,
   input  logic                 act_valid,
   output logic                 wb_write_enable,
   output logic [3:0]           wb_rd_address,
   output logic [DATA_BITS-1:0] wb_data,
   output logic                 wb_ready,
   output logic                 wb_illegal
);

   localparam int unsigned RD_BITS  = 4;
   localparam int unsigned MUX_BITS = 3;

   localparam logic [2:0] CORE_EXECUTE = 3'b101;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;

   localparam logic [MUX_BITS-1:0] MUX_MEM   = 3'b001;
   localparam logic [MUX_BITS-1:0] MUX_CONST = 3'b010;
   localparam logic [MUX_BITS-1:0] MUX_FMA   = 3'b011;
   localparam logic [MUX_BITS-1:0] MUX_ACT   = 3'b100;

   // Registers r13..r15 are read-only; writes to them are dropped and flagged.
   localparam logic [RD_BITS-1:0] RD_FIRST_READ_ONLY = 4'd13;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [RD_BITS-1:0]   rd_q, rd_d;
   logic [MUX_BITS-1:0]  mux_q, mux_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 we_d;
   logic [RD_BITS-1:0]   addr_d;
   logic [DATA_BITS-1:0] wdata_d;
   logic                 ready_d;
   logic                 illegal_d;

   logic                 variable_latency_c;
   logic [DATA_BITS-1:0] fixed_data_c;
   logic                 unit_valid_c;
   logic [DATA_BITS-1:0] unit_data_c;

   // Decode of the incoming instruction's source: fixed-latency data is available now.
   always_comb begin
      variable_latency_c = 1'b0;
      fixed_data_c       = alu_out;
      case (decoded_reg_input_mux)
         MUX_MEM, MUX_FMA, MUX_ACT: variable_latency_c = 1'b1;
         MUX_CONST:                 fixed_data_c = DATA_BITS'($signed(decoded_immediate));
         default:                   fixed_data_c = alu_out;
      endcase
   end

   // Strobe and data of the unit latched for the pending instruction; others are ignored.
   always_comb begin
      unit_valid_c = 1'b0;
      unit_data_c  = lsu_out;
      case (mux_q)
         MUX_MEM: begin
            unit_valid_c = lsu_valid;
            unit_data_c  = lsu_out;
         end
         MUX_FMA: begin
            unit_valid_c = fma_valid;
            unit_data_c  = fma_out;
         end
         MUX_ACT: begin
            unit_valid_c = act_valid;
            unit_data_c  = act_out;
         end
         default: unit_valid_c = 1'b0;
      endcase
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      mux_d     = mux_q;
      data_d    = data_q;
      we_d      = 1'b0;
      addr_d    = wb_rd_address;
      wdata_d   = wb_data;
      illegal_d = wb_illegal;

      if (!enable) begin
         state_d = S_IDLE;
         rd_d    = '0;
         mux_d   = '0;
         data_d  = '0;
         addr_d  = '0;
         wdata_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (core_state == CORE_EXECUTE && decoded_reg_write_enable) begin
                  rd_d  = decoded_rd_address;
                  mux_d = decoded_reg_input_mux;
                  if (variable_latency_c) begin
                     state_d = S_COLLECT;
                  end else begin
                     data_d  = fixed_data_c;
                     state_d = S_HOLD;
                  end
               end
            end
            S_COLLECT: begin
               // A premature UPDATE here is ignored; the write waits for HOLD.
               if (unit_valid_c) begin
                  data_d  = unit_data_c;
                  state_d = S_HOLD;
               end
            end
            S_HOLD: begin
               if (core_state == CORE_UPDATE) begin
                  state_d = S_IDLE;
                  if (rd_q < RD_FIRST_READ_ONLY) begin
                     we_d    = 1'b1;
                     addr_d  = rd_q;
                     wdata_d = data_q;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      ready_d = (state_d != S_COLLECT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         rd_q            <= '0;
         mux_q           <= '0;
         data_q          <= '0;
         wb_write_enable <= 1'b0;
         wb_rd_address   <= '0;
         wb_data         <= '0;
         wb_ready        <= 1'b1;
         wb_illegal      <= 1'b0;
      end else begin
         state_q         <= state_d;
         rd_q            <= rd_d;
         mux_q           <= mux_d;
         data_q          <= data_d;
         wb_write_enable <= we_d;
         wb_rd_address   <= addr_d;
         wb_data         <= wdata_d;
         wb_ready        <= ready_d;
         wb_illegal      <= illegal_d;
      end
   end

endmodule

// File: tb/tb_thread_writeback.sv
// Self-checking bench for thread_writeback: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_thread_writeback;

   localparam int unsigned DW = 16;

   localparam logic [2:0] C_IDLE = 3'b000, C_WAIT = 3'b100, C_EXEC = 3'b101,
                          C_UPD = 3'b110, C_DONE = 3'b111;
   localparam logic [2:0] M_ALU = 3'd0, M_MEM = 3'd1, M_CONST = 3'd2, M_FMA = 3'd3, M_ACT = 3'd4;

   logic          clk = 1'b0;
   logic          reset, enable;
   logic [2:0]    core_state;
   logic          dec_we;
   logic [3:0]    dec_rd;
   logic [2:0]    dec_mux;
   logic [7:0]    dec_imm;
   logic [DW-1:0] alu_out, lsu_out, fma_out, act_out;
   logic          lsu_valid, fma_valid, act_valid;
   logic          wb_write_enable, wb_ready, wb_illegal;
   logic [3:0]    wb_rd_address;
   logic [DW-1:0] wb_data;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: one pending instruction record plus the expected outputs.
   bit            m_busy = 0, m_have = 0;
   logic [3:0]    m_rd = '0;
   logic [2:0]    m_sel = '0;
   logic [DW-1:0] m_val = '0;
   logic          e_we = 0, e_ready = 1, e_ill = 0, e_known = 1;
   logic [3:0]    e_addr = '0;
   logic [DW-1:0] e_data = '0;
   logic          prev_we = 0;

   always #5 clk = ~clk;

   thread_writeback #(.DATA_BITS(DW)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .enable                   (enable),
      .core_state               (core_state),
      .decoded_reg_write_enable (dec_we),
      .decoded_rd_address       (dec_rd),
      .decoded_reg_input_mux    (dec_mux),
      .decoded_immediate        (dec_imm),
      .alu_out                  (alu_out),
      .lsu_out                  (lsu_out),
      .lsu_valid                (lsu_valid),
      .fma_out                  (fma_out),
      .fma_valid                (fma_valid),
      .act_out                  (act_out),
      .act_valid                (act_valid),
      .wb_write_enable          (wb_write_enable),
      .wb_rd_address            (wb_rd_address),
      .wb_data                  (wb_data),
      .wb_ready                 (wb_ready),
      .wb_illegal               (wb_illegal)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic [DW-1:0] imm_ext;
      imm_ext = {{8{dec_imm[7]}}, dec_imm};
      if (reset) begin
         m_busy = 0; e_we = 0; e_addr = '0; e_data = '0; e_ill = 0; e_known = 1;
      end else if (!enable) begin
         m_busy = 0; e_we = 0; e_addr = '0; e_data = '0; e_known = 1;
      end else begin
         if (e_we) e_known = 0;
         e_we = 0;
         if (!m_busy) begin
            if (core_state == C_EXEC && dec_we) begin
               m_busy = 1;
               m_rd   = dec_rd;
               m_sel  = dec_mux;
               m_have = !(dec_mux == M_MEM || dec_mux == M_FMA || dec_mux == M_ACT);
               m_val  = (dec_mux == M_CONST) ? imm_ext : alu_out;
            end
         end else if (!m_have) begin
            if (m_sel == M_MEM && lsu_valid) begin m_have = 1; m_val = lsu_out; end
            if (m_sel == M_FMA && fma_valid) begin m_have = 1; m_val = fma_out; end
            if (m_sel == M_ACT && act_valid) begin m_have = 1; m_val = act_out; end
         end else if (core_state == C_UPD) begin
            m_busy = 0;
            if (m_rd <= 4'd12) begin
               e_we = 1; e_addr = m_rd; e_data = m_val; e_known = 1;
            end else begin
               e_ill = 1;
            end
         end
      end
      e_ready = !(m_busy && !m_have);
   endtask

   // One clock: update the model, clock the DUT, then compare away from the edge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("we", wb_write_enable, e_we);
      check("illegal", wb_illegal, e_ill);
      if (enable || reset) check("ready", wb_ready, e_ready);
      if (e_known) begin
         check("addr", wb_rd_address, e_addr);
         check("data", wb_data, e_data);
      end
      check("we_twice", prev_we && wb_write_enable, 1'b0);
      prev_we = wb_write_enable;
   endtask

   task automatic quiet();
      core_state = C_IDLE; dec_we = 0; dec_rd = '0; dec_mux = '0; dec_imm = '0;
      lsu_valid = 0; fma_valid = 0; act_valid = 0;
   endtask

   task automatic issue(input logic [3:0] rd, input logic [2:0] mux, input logic [7:0] imm);
      core_state = C_EXEC; dec_we = 1; dec_rd = rd; dec_mux = mux; dec_imm = imm;
      cycle();
      dec_we = 0;
   endtask

   initial begin
      quiet();
      enable = 1; reset = 1;
      alu_out = '0; lsu_out = '0; fma_out = '0; act_out = '0;
      cycle(); cycle();
      reset = 0;
      check("rst_we", wb_write_enable, 1'b0);
      check("rst_ready", wb_ready, 1'b1);
      check("rst_data", wb_data, 16'h0000);

      // CONST immediates, negative and positive
      issue(4'd3, M_CONST, 8'hF0);
      check("const_ready", wb_ready, 1'b1);
      core_state = C_UPD; cycle();
      check("const_we", wb_write_enable, 1'b1);
      check("const_rd", wb_rd_address, 4'd3);
      check("const_neg", wb_data, 16'hFFF0);
      core_state = C_DONE; cycle();
      check("const_pulse", wb_write_enable, 1'b0);
      issue(4'd3, M_CONST, 8'h7F);
      core_state = C_UPD; cycle();
      check("const_pos", wb_data, 16'h007F);
      quiet(); cycle();

      // FMA with four-cycle latency
      fma_out = 16'h1111;
      issue(4'd5, M_FMA, 8'h00);
      check("fma_busy0", wb_ready, 1'b0);
      core_state = C_WAIT;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("fma_busy", wb_ready, 1'b0);
      end
      fma_valid = 1; fma_out = 16'h4000; cycle();
      check("fma_ready", wb_ready, 1'b1);
      fma_valid = 0; fma_out = 16'h2222;
      core_state = C_UPD; cycle();
      check("fma_we", wb_write_enable, 1'b1);
      check("fma_rd", wb_rd_address, 4'd5);
      check("fma_data", wb_data, 16'h4000);
      quiet(); cycle();

      // Foreign strobe must be ignored
      issue(4'd7, M_MEM, 8'h00);
      core_state = C_WAIT;
      act_valid = 1; act_out = 16'h1234; cycle();
      check("foreign_ready", wb_ready, 1'b0);
      act_valid = 0; lsu_valid = 1; lsu_out = 16'h0ABC; cycle();
      lsu_valid = 0;
      core_state = C_UPD; cycle();
      check("foreign_data", wb_data, 16'h0ABC);
      quiet(); cycle();

      // Premature UPDATE while collecting, then strobe during UPDATE
      issue(4'd8, M_FMA, 8'h00);
      core_state = C_UPD; cycle();
      check("early_upd", wb_write_enable, 1'b0);
      fma_valid = 1; fma_out = 16'h5A5A; cycle();
      check("strobe_upd", wb_write_enable, 1'b0);
      fma_valid = 0; cycle();
      check("late_we", wb_write_enable, 1'b1);
      check("late_data", wb_data, 16'h5A5A);
      quiet(); cycle();

      // Read-only destination
      alu_out = 16'h0001;
      issue(4'd14, M_ALU, 8'h00);
      core_state = C_UPD; cycle();
      check("ro_we", wb_write_enable, 1'b0);
      check("ro_illegal", wb_illegal, 1'b1);
      issue(4'd2, M_CONST, 8'h01);
      core_state = C_UPD; cycle();
      check("ro_sticky", wb_illegal, 1'b1);
      check("legal_we", wb_write_enable, 1'b1);
      quiet(); cycle();

      // Reset while collecting
      issue(4'd4, M_ACT, 8'h00);
      reset = 1; cycle();
      reset = 0;
      check("rstc_illegal", wb_illegal, 1'b0);
      check("rstc_ready", wb_ready, 1'b1);
      act_valid = 1; act_out = 16'h7777; core_state = C_WAIT; cycle();
      act_valid = 0; core_state = C_UPD; cycle();
      check("rstc_we", wb_write_enable, 1'b0);
      check("rstc_addr", wb_rd_address, 4'd0);
      quiet(); cycle();

      // Enable dropped while holding
      alu_out = 16'h3333;
      issue(4'd6, M_ALU, 8'h00);
      enable = 0; core_state = C_IDLE; cycle();
      enable = 1; core_state = C_UPD; cycle();
      check("en_we", wb_write_enable, 1'b0);
      cycle();
      check("en_we2", wb_write_enable, 1'b0);
      quiet(); cycle();

      // Instruction without register write
      core_state = C_EXEC; dec_we = 0; dec_rd = 4'd1; cycle();
      check("nowr_ready", wb_ready, 1'b1);
      core_state = C_UPD; cycle();
      check("nowr_we", wb_write_enable, 1'b0);
      quiet(); cycle();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         core_state = 3'($urandom);
         dec_we     = 1'($urandom);
         dec_rd     = 4'($urandom);
         dec_mux    = 3'($urandom);
         dec_imm    = 8'($urandom);
         alu_out    = 16'($urandom);
         lsu_out    = 16'($urandom);
         fma_out    = 16'($urandom);
         act_out    = 16'($urandom);
         lsu_valid  = ($urandom_range(0, 3) == 0);
         fma_valid  = ($urandom_range(0, 3) == 0);
         act_valid  = ($urandom_range(0, 3) == 0);
         enable     = ($urandom_range(0, 39) != 0);
         reset      = ($urandom_range(0, 149) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
